// File: rtl/bru_redirect.sv
// rtl/bru_redirect.sv - Branch resolve unit: mispredict redirect, refetch squash and predictor update FIFO.
module bru_redirect #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_res_valid,
    output logic            o_res_ready,
    input  logic [XLEN-1:0] i_res_pc,
    input  logic            i_res_is_cond,
    input  logic            i_res_taken,
    input  logic [XLEN-1:0] i_res_target,
    input  logic            i_res_pred_taken,
    input  logic [XLEN-1:0] i_res_pred_target,
    input  logic            i_flush_done,
    input  logic            i_upd_stall,
    output logic [XLEN-1:0] o_exu_pcRedirect_npc,
    output logic            o_exu_pcRedirect_npc_valid,
    output logic [XLEN-1:0] o_pc_jumpsrc,
    output logic [XLEN-1:0] o_pc_jumpdst,
    output logic            o_ubtb_update,
    output logic            o_upht_update,
    output logic            o_ghr_update,
    output logic            o_satCnt_update,
    output logic            o_last_jump,
    output logic            o_flushing,
    output logic [31:0]     o_mispred_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            is_cond;
        logic            ubtb_wr;
    } upd_t;

    state_t          state_q, state_d;
    upd_t            mem_q [DEPTH];
    logic [AW:0]     wptr_q, rptr_q;
    logic            full, empty, fire, push, pop, mispred;
    logic            redir_valid_q, upd_strobe_q, upd_cond_q, upd_ubtb_q, last_jump_q;
    logic [XLEN-1:0] npc_q, src_q, dst_q;
    logic [31:0]     cnt_q;
    upd_t            wr_entry;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign fire  = i_res_valid && o_res_ready;
    assign push  = fire && (state_q == S_IDLE);
    assign pop   = !empty && !i_upd_stall;

    assign mispred = (i_res_pred_taken != i_res_taken) ||
                     (i_res_taken && (i_res_pred_target != i_res_target));

    assign wr_entry = '{pc:      i_res_pc,
                        target:  i_res_target,
                        taken:   i_res_taken,
                        is_cond: i_res_is_cond,
                        ubtb_wr: i_res_taken && (!i_res_pred_taken ||
                                                 (i_res_pred_target != i_res_target))};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fire && mispred) state_d = S_FLUSH;
            S_FLUSH: if (i_flush_done)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Dropping in FLUSH means the front end never sees back-pressure while squashing.
    always_comb begin
        o_flushing  = (state_q == S_FLUSH);
        o_res_ready = (state_q == S_FLUSH) || !full;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            redir_valid_q <= 1'b0;
            npc_q         <= '0;
            cnt_q         <= '0;
        end else begin
            redir_valid_q <= push && mispred;
            if (push && mispred) begin
                npc_q <= i_res_taken ? i_res_target : i_res_pc + XLEN'(4);
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Strobes pulse for one cycle; the address/direction fields keep the last popped entry.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            upd_strobe_q <= 1'b0;
            upd_cond_q   <= 1'b0;
            upd_ubtb_q   <= 1'b0;
            last_jump_q  <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
        end else begin
            upd_strobe_q <= pop;
            upd_cond_q   <= pop && mem_q[rptr_q[AW-1:0]].is_cond;
            upd_ubtb_q   <= pop && mem_q[rptr_q[AW-1:0]].ubtb_wr;
            if (pop) begin
                src_q       <= mem_q[rptr_q[AW-1:0]].pc;
                dst_q       <= mem_q[rptr_q[AW-1:0]].target;
                last_jump_q <= mem_q[rptr_q[AW-1:0]].taken;
            end
        end
    end

    assign o_exu_pcRedirect_npc       = npc_q;
    assign o_exu_pcRedirect_npc_valid = redir_valid_q;
    assign o_mispred_cnt              = cnt_q;
    assign o_pc_jumpsrc               = src_q;
    assign o_pc_jumpdst               = dst_q;
    assign o_last_jump                = last_jump_q;
    assign o_ubtb_update              = upd_strobe_q && upd_ubtb_q;
    assign o_upht_update              = upd_strobe_q && upd_cond_q;
    assign o_ghr_update               = upd_strobe_q && upd_cond_q;
    assign o_satCnt_update            = upd_strobe_q && upd_cond_q;

endmodule

// File: tb/tb_bru_redirect.sv
// tb/tb_bru_redirect.sv - Directed bench for bru_redirect against a queue-based reference model.
module tb_bru_redirect;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            res_valid = 1'b0;
    logic            res_ready;
    logic [XLEN-1:0] res_pc = '0;
    logic            res_is_cond = 1'b0;
    logic            res_taken = 1'b0;
    logic [XLEN-1:0] res_target = '0;
    logic            res_pred_taken = 1'b0;
    logic [XLEN-1:0] res_pred_target = '0;
    logic            flush_done = 1'b0;
    logic            upd_stall = 1'b0;
    logic [XLEN-1:0] npc, jumpsrc, jumpdst;
    logic            npc_valid, ubtb_upd, upht_upd, ghr_upd, sat_upd, last_jump, flushing;
    logic [31:0]     mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bru_redirect #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .i_clk                      (clk),
        .i_rstn                     (rstn),
        .i_res_valid                (res_valid),
        .o_res_ready                (res_ready),
        .i_res_pc                   (res_pc),
        .i_res_is_cond              (res_is_cond),
        .i_res_taken                (res_taken),
        .i_res_target               (res_target),
        .i_res_pred_taken           (res_pred_taken),
        .i_res_pred_target          (res_pred_target),
        .i_flush_done               (flush_done),
        .i_upd_stall                (upd_stall),
        .o_exu_pcRedirect_npc       (npc),
        .o_exu_pcRedirect_npc_valid (npc_valid),
        .o_pc_jumpsrc               (jumpsrc),
        .o_pc_jumpdst               (jumpdst),
        .o_ubtb_update              (ubtb_upd),
        .o_upht_update              (upht_upd),
        .o_ghr_update               (ghr_upd),
        .o_satCnt_update            (sat_upd),
        .o_last_jump                (last_jump),
        .o_flushing                 (flushing),
        .o_mispred_cnt              (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tgt;
        logic            taken;
        logic            cond;
        logic            ubtb;
    } rec_t;

    rec_t            m_q[$];
    rec_t            m_e;
    logic            m_flush = 1'b0;
    logic            m_nflush;
    logic            m_valid = 1'b0;
    logic [XLEN-1:0] m_npc = '0;
    logic [31:0]     m_cnt = '0;
    logic [XLEN-1:0] m_src = '0, m_dst = '0;
    logic            m_last = 1'b0, m_ubtb = 1'b0, m_cond = 1'b0;
    logic            m_ready, m_fire, m_mis;

    // Model: queue holds pending training records; outputs are what the next cycle must show.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            m_flush = 1'b0; m_valid = 1'b0; m_npc = '0; m_cnt = '0;
            m_src = '0; m_dst = '0; m_last = 1'b0; m_ubtb = 1'b0; m_cond = 1'b0;
        end else begin
            m_ready = m_flush || (m_q.size() < DEPTH);
            m_fire  = res_valid && m_ready;
            m_mis   = (res_pred_taken != res_taken) || (res_taken && res_pred_target != res_target);
            m_valid = 1'b0; m_ubtb = 1'b0; m_cond = 1'b0;
            if (m_q.size() > 0 && !upd_stall) begin
                m_e    = m_q.pop_front();
                m_src  = m_e.pc; m_dst = m_e.tgt; m_last = m_e.taken;
                m_ubtb = m_e.ubtb; m_cond = m_e.cond;
            end
            m_nflush = m_flush;
            if (!m_flush && m_fire) begin
                m_e.pc = res_pc; m_e.tgt = res_target; m_e.taken = res_taken;
                m_e.cond = res_is_cond;
                m_e.ubtb = res_taken && (!res_pred_taken || res_pred_target != res_target);
                m_q.push_back(m_e);
                if (m_mis) begin
                    m_valid  = 1'b1;
                    m_npc    = res_taken ? res_target : res_pc + 32'd4;
                    m_cnt    = m_cnt + 32'd1;
                    m_nflush = 1'b1;
                end
            end
            if (m_flush && flush_done) m_nflush = 1'b0;
            m_flush = m_nflush;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("res_ready",   32'(res_ready), 32'(m_flush || (m_q.size() < DEPTH)));
        chk("npc_valid",   32'(npc_valid), 32'(m_valid));
        chk("npc",         npc, m_npc);
        chk("flushing",    32'(flushing), 32'(m_flush));
        chk("mispred_cnt", mispred_cnt, m_cnt);
        chk("jumpsrc",     jumpsrc, m_src);
        chk("jumpdst",     jumpdst, m_dst);
        chk("last_jump",   32'(last_jump), 32'(m_last));
        chk("ubtb_upd",    32'(ubtb_upd), 32'(m_ubtb));
        chk("upht_upd",    32'(upht_upd), 32'(m_cond));
        chk("ghr_upd",     32'(ghr_upd), 32'(m_cond));
        chk("sat_upd",     32'(sat_upd), 32'(m_cond));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic cond, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic fd);
        res_valid = v; res_pc = pc; res_is_cond = cond; res_taken = tk;
        res_target = tgt; res_pred_taken = ptk; res_pred_target = ptgt; flush_done = fd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        #1;
        compare();
        chk("reset_ready", 32'(res_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Correct cond prediction: no redirect, update one cycle later.
        drive(1, 32'h100, 1, 1, 32'h180, 1, 32'h180, 0);
        tick(); idle();
        chk("t1_no_redir", 32'(npc_valid), 32'd0);
        tick();
        chk("t1_upht", 32'(upht_upd), 32'd1);
        chk("t1_ubtb", 32'(ubtb_upd), 32'd0);
        chk("t1_src",  jumpsrc, 32'h100);
        chk("t1_dst",  jumpdst, 32'h180);
        chk("t1_last", 32'(last_jump), 32'd1);

        // Direction mispredict, younger resolve dropped, refetch confirmed.
        drive(1, 32'h200, 1, 0, 32'h280, 1, 32'h280, 0);
        tick();
        chk("t2_valid", 32'(npc_valid), 32'd1);
        chk("t2_npc",   npc, 32'h204);
        chk("t2_flush", 32'(flushing), 32'd1);
        chk("t2_cnt",   mispred_cnt, 32'd1);
        drive(1, 32'h208, 1, 1, 32'h300, 0, 32'h0, 0);
        tick();
        chk("t2_drop_valid", 32'(npc_valid), 32'd0);
        drive(1, 32'h20c, 1, 1, 32'h300, 0, 32'h0, 1);
        tick(); idle();
        chk("t2_idle", 32'(flushing), 32'd0);
        chk("t2_cnt_hold", mispred_cnt, 32'd1);
        tick();
        chk("t2_no_upd", 32'(upht_upd), 32'd0);

        // Target mispredict on unconditional jump.
        drive(1, 32'h300, 0, 1, 32'h400, 1, 32'h380, 0);
        tick(); idle();
        chk("t3_npc", npc, 32'h400);
        tick();
        chk("t3_ubtb", 32'(ubtb_upd), 32'd1);
        chk("t3_upht", 32'(upht_upd), 32'd0);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1);
        tick(); idle();

        // Back-pressure: fill FIFO under stall, then drain in order.
        upd_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h1000 + 32'(i * 16), 1, i[0], 32'h2000 + 32'(i * 16), i[0],
                  32'h2000 + 32'(i * 16), 0);
            tick();
        end
        chk("t4_full", 32'(res_ready), 32'd0);
        drive(1, 32'h1ff0, 1, 0, 32'h0, 0, 32'h0, 0);
        tick(); idle();
        upd_stall = 1'b0;
        tick();
        chk("t4_ready_back", 32'(res_ready), 32'd1);
        chk("t4_first_src",  jumpsrc, 32'h1000);
        drive(1, 32'h1100, 1, 0, 32'h0, 0, 32'h0, 0);
        tick(); idle();
        for (int i = 0; i < DEPTH + 1; i++) tick();
        chk("t4_last_src", jumpsrc, 32'h1100);

        // Mispredict coinciding with flush_done in IDLE; npc wrap.
        drive(1, 32'h500, 1, 0, 32'h0, 1, 32'h0, 1);
        tick(); idle();
        chk("t5_flush", 32'(flushing), 32'd1);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1);
        tick();
        drive(1, 32'hFFFF_FFFC, 1, 0, 32'h0, 1, 32'h10, 0);
        tick(); idle();
        chk("t5_wrap", npc, 32'h0);
        chk("t5_cnt",  mispred_cnt, 32'd4);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1);
        tick(); idle();
        tick(); tick();

        // Asynchronous reset mid-FLUSH with two FIFO entries pending.
        upd_stall = 1'b1;
        drive(1, 32'h600, 1, 1, 32'h700, 1, 32'h700, 0);
        tick();
        drive(1, 32'h604, 1, 1, 32'h800, 0, 32'h0, 0);
        tick(); idle();
        chk("t6_pre_flush", 32'(flushing), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        compare();
        chk("t6_cnt0",  mispred_cnt, 32'd0);
        chk("t6_ready", 32'(res_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        upd_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_strobe", 32'({ubtb_upd, upht_upd, ghr_upd, sat_upd}), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bru_redirect.md
Name: bru_redirect

Overview:
- Sits at the execute end of the front-end redirect/update interface. It receives resolved branch records from the EXU branch unit and detects mispredictions.
- On a misprediction it produces the EXU redirect (npc + valid) consumed by the IF0 stage.
- It buffers predictor training records in a small FIFO and drains them one per cycle as the uBTB/uPHT/GHR/saturating-counter update strobes.
- It squashes younger resolves until the front end confirms refetch.

Parameters:
- XLEN, 32, address/PC width (equals MXLEN).
- DEPTH, 4, update FIFO entries; power of two, >=2.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_res_valid  in  1  resolved branch record valid.
- o_res_ready  out  1  record accepted when valid&&ready.
- i_res_pc  in  XLEN  branch PC.
- i_res_is_cond  in  1  conditional branch (0 = unconditional jump).
- i_res_taken  in  1  actual direction.
- i_res_target  in  XLEN  actual target.
- i_res_pred_taken  in  1  predicted direction.
- i_res_pred_target  in  XLEN  predicted target.
- i_flush_done  in  1  front end has refetched from the redirect PC.
- i_upd_stall  in  1  predictor busy; hold the update FIFO head.
- o_exu_pcRedirect_npc  out  XLEN  redirect PC.
- o_exu_pcRedirect_npc_valid  out  1  one-cycle redirect pulse.
- o_pc_jumpsrc  out  XLEN  update source PC.
- o_pc_jumpdst  out  XLEN  update target.
- o_ubtb_update  out  1  write uBTB entry.
- o_upht_update  out  1  update uPHT.
- o_ghr_update  out  1  shift GHR.
- o_satCnt_update  out  1  update saturating counter.
- o_last_jump  out  1  actual taken bit of the update.
- o_flushing  out  1  FSM is in FLUSH.
- o_mispred_cnt  out  32  mispredict count, wraps at 2^32.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, count 0.
- Accept: fire = i_res_valid && o_res_ready.
  - o_res_ready = 1 in FLUSH, because records are dropped there.
  - o_res_ready = !full in IDLE.
- Misprediction, evaluated on a fire in IDLE, is true when either holds:
  - i_res_pred_taken != i_res_taken;
  - i_res_taken && i_res_pred_target != i_res_target.
- Redirect, driven in the cycle after a mispredicting fire:
  - o_exu_pcRedirect_npc_valid = 1 for exactly one cycle.
  - npc = i_res_target if taken, else i_res_pc + 4 (modulo 2^XLEN).
  - npc holds its last value when valid = 0.
  - o_mispred_cnt increments in the same cycle as the pulse.
- FSM states IDLE and FLUSH:
  - IDLE -> FLUSH on a mispredicting fire.
  - FLUSH -> IDLE on i_flush_done.
  - In FLUSH, fires are discarded: no redirect, no enqueue, no count.
  - i_flush_done in IDLE is ignored.
  - A mispredict in IDLE in the same cycle as i_flush_done goes to FLUSH.
  - A resolve in the cycle that FLUSH sees i_flush_done is still dropped.
- Enqueue: every fire in IDLE, correct or not, writes {pc, target, taken, is_cond, ubtb_wr}.
  - ubtb_wr = taken && (!pred_taken || pred_target != target).
- Dequeue: when FIFO not empty and !i_upd_stall, the head is presented registered (1-cycle latency) and popped.
  - o_pc_jumpsrc = pc, o_pc_jumpdst = target, o_last_jump = taken.
  - o_ubtb_update = ubtb_wr.
  - o_upht_update = o_ghr_update = o_satCnt_update = is_cond.
  - Strobes are 1-cycle pulses; the src/dst/last_jump fields hold their last value otherwise.
- FIFO corner cases:
  - Push and pop in the same cycle are allowed whenever not full.
  - Full blocks a push even if a pop occurs that cycle (ready is not combinationally dependent on pop).
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Reset asserted mid-operation: all state clears immediately (asynchronous), including pending redirect and FIFO contents.

Test Plan:
1. Correct prediction: cond branch pc=0x100, taken=1, target=0x180, pred_taken=1, pred_target=0x180 -> no redirect; one cycle later upht/ghr/satCnt=1, ubtb=0, jumpsrc=0x100, jumpdst=0x180, last_jump=1.
2. Direction mispredict: pc=0x200, taken=0, pred_taken=1 -> next cycle redirect_valid=1, npc=0x204, o_flushing=1, o_mispred_cnt=1; resolve pc=0x208 in FLUSH dropped (no update, no redirect); i_flush_done -> IDLE next cycle.
3. Target mispredict: uncond jump pc=0x300, taken=1, target=0x400, pred_target=0x380 -> npc=0x400; update has ubtb=1, upht/ghr/satCnt=0.
4. Back-pressure: i_upd_stall=1, four correct resolves -> o_res_ready=0 after the fourth; release stall -> four updates on consecutive cycles in FIFO order; ready returns to 1 after the first pop.
5. Simultaneous events: mispredict fire with i_flush_done=1 in IDLE -> ends in FLUSH; npc wrap at pc=0xFFFFFFFC, not taken, mispredicted -> npc=0x00000000.
6. Reset mid-FLUSH with 2 FIFO entries -> all outputs 0, ready=1, no update strobes after release.
